// File: rtl/split_radio_pkg.sv
// Shared types and helpers for the split-radio scheduler.
package split_radio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest requester ID (NUM_REQ up to 8); tags carry this width and the
  // top keeps only the low bits it needs.
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Chain input level pair when nothing is launched.
  localparam logic IDLE_PLUS  = 1'b0;
  localparam logic IDLE_MINUS = 1'b0;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/split_radio_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module split_radio_rr_arb
  import split_radio_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_vld
);

  logic [ID_W-1:0] ptr;

  // First requesting index at or after the pointer wins, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_vld && req[idx]) begin
          grant_vld  = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  // Pointer moves just past the winner; unchanged when nobody is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/split_radio_scheduler.sv
// Split-radio scheduler: round-robin launch of differential bits into a
// fixed-latency chain, tag tracking, and credit-protected return FIFO.
// Optional macro SPLIT_RADIO_PAIRCHK_EN enables the sticky pair-check Err.
module split_radio_scheduler
  import split_radio_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int STAGES  = 4,
  parameter  int CREDITS = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] Req_Valid,
  input  logic [NUM_REQ-1:0] Req_Bit,
  output logic [NUM_REQ-1:0] Req_Ready,
  output logic               Drive_Plus,
  output logic               Drive_Minus,
  input  logic               Chain_Plus,
  input  logic               Chain_Minus,
  output logic               Rsp_Valid,
  input  logic               Rsp_Ready,
  output logic               Rsp_Bit,
  output logic [ID_W-1:0]    Rsp_Id,
  input  logic               Flush,
  output logic               Busy,
  output logic               Err
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int PTR_W = (CREDITS <= 1) ? 1 : $clog2(CREDITS);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == CREDITS - 1) ? '0 : p + PTR_W'(1);
  endfunction

  state_t               state, state_nxt;
  logic                 arb_en, grant_vld;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 drive_plus_p0, drive_minus_p0;
  tag_t                 tag_p0;
  tag_t                 tag_pipe [STAGES];
  tag_t                 tag_exit;
  logic                 in_flight;
  logic                 fifo_bit [CREDITS];
  logic [ID_W-1:0]      fifo_id  [CREDITS];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt, credits;
  logic                 fifo_empty, push, pop;
  logic                 id_unused;

  split_radio_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .en        (arb_en),
    .req       (Req_Valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign tag_exit   = tag_pipe[STAGES-1];
  assign id_unused  = ^tag_exit.id;
  assign push       = tag_exit.valid;
  assign fifo_empty = (fifo_cnt == '0);
  assign Rsp_Valid  = !fifo_empty;
  assign Rsp_Bit    = Rsp_Valid & fifo_bit[rd_ptr];
  assign Rsp_Id     = Rsp_Valid ? fifo_id[rd_ptr] : '0;
  assign pop        = Rsp_Valid & Rsp_Ready;
  assign Req_Ready  = grant;
  assign Drive_Plus  = drive_plus_p0;
  assign Drive_Minus = drive_minus_p0;
  assign Busy       = (state != IDLE) | in_flight | !fifo_empty;

  // Any tag still travelling between launch and capture.
  always_comb begin
    in_flight = tag_p0.valid;
    for (int i = 0; i < STAGES; i++) in_flight = in_flight | tag_pipe[i].valid;
  end

  // Next-state and grant enable; Flush beats a same-cycle grant.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        if (Flush)           state_nxt = DRAIN;
        else if (|Req_Valid) state_nxt = RUN;
      end
      RUN: begin
        arb_en = !Flush && (credits != '0);
        if (Flush) state_nxt = DRAIN;
        else if (!(|Req_Valid) && !in_flight && fifo_empty) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!in_flight && fifo_empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- launch stage p0: drive pair and tag registered off the grant ----
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      drive_plus_p0  <= IDLE_PLUS;
      drive_minus_p0 <= IDLE_MINUS;
      tag_p0         <= '0;
    end else if (grant_vld) begin
      drive_plus_p0  <= Req_Bit[grant_id];
      drive_minus_p0 <= ~Req_Bit[grant_id];
      tag_p0.valid   <= 1'b1;
      tag_p0.id      <= ID_MAX_W'(grant_id);
    end else begin
      drive_plus_p0  <= IDLE_PLUS;
      drive_minus_p0 <= IDLE_MINUS;
      tag_p0         <= '0;
    end
  end

  // ---- chain tracking: tag follows the bit through STAGES cycles ----
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < STAGES; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_p0;
      for (int i = 1; i < STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // ---- capture: chain output written into the return FIFO at tag exit ----
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_bit[wr_ptr] <= Chain_Plus;
      fifo_id[wr_ptr]  <= tag_exit.id[ID_W-1:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits bound launched-but-unpopped bits to the FIFO depth.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      credits <= CNT_W'(CREDITS);
    end else begin
      case ({grant_vld, pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

`ifdef SPLIT_RADIO_PAIRCHK_EN
  logic err_q;

  // A tagged sample with equal legs is a broken differential pair; sticky.
  always_ff @(posedge Clock) begin
    if (!Reset_n) err_q <= 1'b0;
    else if (tag_exit.valid && (Chain_Plus == Chain_Minus)) err_q <= 1'b1;
  end

  assign Err = err_q;
`else
  logic chain_minus_unused;
  assign chain_minus_unused = Chain_Minus;
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_split_radio_scheduler.sv
// Directed bench for split_radio_scheduler with a behavioural chain delay line.
module tb_split_radio_scheduler;

  localparam int NUM_REQ = 4;
  localparam int STAGES  = 4;
  localparam int CREDITS = 8;
`ifdef SPLIT_RADIO_PAIRCHK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic [3:0]   Req_Valid = '0;
  logic [3:0]   Req_Bit = '0;
  logic [3:0]   Req_Ready;
  logic         Drive_Plus, Drive_Minus;
  logic         Chain_Plus, Chain_Minus;
  logic         Rsp_Valid;
  logic         Rsp_Ready = 1'b1;
  logic         Rsp_Bit;
  logic [1:0]   Rsp_Id;
  logic         Flush = 1'b0;
  logic         Busy, Err;
  logic         force_plus = 1'b0, force_minus = 1'b0;
  logic [STAGES-1:0] dl_p = '0, dl_m = '0;

  int checks = 0;
  int failures = 0;
  int gq[$];
  int rq_id[$];
  int rq_bit[$];

  split_radio_scheduler #(.NUM_REQ(NUM_REQ), .STAGES(STAGES), .CREDITS(CREDITS)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req_Valid(Req_Valid), .Req_Bit(Req_Bit),
    .Req_Ready(Req_Ready), .Drive_Plus(Drive_Plus), .Drive_Minus(Drive_Minus),
    .Chain_Plus(Chain_Plus), .Chain_Minus(Chain_Minus), .Rsp_Valid(Rsp_Valid),
    .Rsp_Ready(Rsp_Ready), .Rsp_Bit(Rsp_Bit), .Rsp_Id(Rsp_Id), .Flush(Flush),
    .Busy(Busy), .Err(Err)
  );

  always #5 Clock = ~Clock;

  // Chain model: STAGES-cycle delay from Drive_* to Chain_*.
  always @(posedge Clock) begin
    dl_p <= {dl_p[STAGES-2:0], Drive_Plus};
    dl_m <= {dl_m[STAGES-2:0], Drive_Minus};
  end
  assign Chain_Plus  = dl_p[STAGES-1] | force_plus;
  assign Chain_Minus = dl_m[STAGES-1] | force_minus;

  // Record grants and accepted responses mid-cycle.
  always @(negedge Clock) begin
    if (Reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) if (Req_Ready[k]) gq.push_back(k);
      if (Rsp_Valid && Rsp_Ready) begin
        rq_id.push_back(int'(Rsp_Id));
        rq_bit.push_back(int'(Rsp_Bit));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Req_Valid = '0; Req_Bit = '0; Flush = 1'b0; Rsp_Ready = 1'b1;
    force_plus = 1'b0; force_minus = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    gq.delete(); rq_id.delete(); rq_bit.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct {
    logic [3:0] v, b; logic rr, fl;
    logic [3:0] rdy; logic dp, dm, rv, rb; logic [1:0] rid; logic busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, b, input logic [3:0] rdy,
                              input logic dp, dm, rv, rb, input logic [1:0] rid,
                              input logic busy);
    vec_t r;
    r.v = v; r.b = b; r.rr = 1'b1; r.fl = 1'b0; r.rdy = rdy; r.dp = dp; r.dm = dm;
    r.rv = rv; r.rb = rb; r.rid = rid; r.busy = busy;
    return r;
  endfunction

  vec_t tbl[20];

  initial begin
    // single bit 1 from requester 2, then bit 0 from requester 1
    tbl[0]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1);
    for (int i = 3; i <= 6; i++) tbl[i] = mk(4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 1, 2, 1);
    tbl[8]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 1);
    for (int i = 13; i <= 16; i++) tbl[i] = mk(4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 1);
    tbl[18] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
    tbl[19] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);

    // reset state
    Reset_n = 1'b0;
    tick(2);
    chk("reset.ready", int'(Req_Ready), 0);
    chk("reset.drive_plus", int'(Drive_Plus), 0);
    chk("reset.drive_minus", int'(Drive_Minus), 0);
    chk("reset.rsp_valid", int'(Rsp_Valid), 0);
    chk("reset.busy", int'(Busy), 0);
    chk("reset.err", int'(Err), 0);
    Reset_n = 1'b1;

    // table-driven single-bit transactions
    for (int i = 0; i < 20; i++) begin
      Req_Valid = tbl[i].v; Req_Bit = tbl[i].b; Rsp_Ready = tbl[i].rr; Flush = tbl[i].fl;
      @(negedge Clock);
      chk($sformatf("row%0d.ready", i), int'(Req_Ready), int'(tbl[i].rdy));
      chk($sformatf("row%0d.drive_plus", i), int'(Drive_Plus), int'(tbl[i].dp));
      chk($sformatf("row%0d.drive_minus", i), int'(Drive_Minus), int'(tbl[i].dm));
      chk($sformatf("row%0d.rsp_valid", i), int'(Rsp_Valid), int'(tbl[i].rv));
      chk($sformatf("row%0d.rsp_bit", i), int'(Rsp_Bit), int'(tbl[i].rb));
      chk($sformatf("row%0d.rsp_id", i), int'(Rsp_Id), int'(tbl[i].rid));
      chk($sformatf("row%0d.busy", i), int'(Busy), int'(tbl[i].busy));
      chk($sformatf("row%0d.err", i), int'(Err), 0);
      @(posedge Clock);
      #1;
    end

    // fairness: all valid for 8 grant cycles
    do_reset();
    Req_Valid = 4'hF; Req_Bit = 4'b1010;
    tick(9);
    Req_Valid = '0;
    tick(12);
    chk("fair.grants", gq.size(), 8);
    chk("fair.rsps", rq_id.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fair.gid%0d", i), qget(gq, i), i % 4);
      chk($sformatf("fair.rid%0d", i), qget(rq_id, i), i % 4);
      chk($sformatf("fair.rbit%0d", i), qget(rq_bit, i), ((i % 4) % 2 == 1) ? 1 : 0);
    end

    // backpressure: credits cap grants at CREDITS
    do_reset();
    Rsp_Ready = 1'b0; Req_Valid = 4'hF; Req_Bit = 4'b0101;
    tick(20);
    chk("bp.grants_capped", gq.size(), CREDITS);
    @(negedge Clock);
    chk("bp.ready_low", int'(Req_Ready), 0);
    chk("bp.rsp_valid", int'(Rsp_Valid), 1);
    @(posedge Clock); #1;
    Rsp_Ready = 1'b1;
    tick(1);
    Rsp_Ready = 1'b0;
    tick(10);
    chk("bp.one_more_grant", gq.size(), CREDITS + 1);
    Req_Valid = '0; Rsp_Ready = 1'b1;
    tick(20);
    chk("bp.rsps", rq_id.size(), CREDITS + 1);
    for (int i = 0; i < CREDITS + 1; i++) begin
      chk($sformatf("bp.gid%0d", i), qget(gq, i), i % 4);
      chk($sformatf("bp.rid%0d", i), qget(rq_id, i), i % 4);
      chk($sformatf("bp.rbit%0d", i), qget(rq_bit, i), ((i % 4) % 2 == 0) ? 1 : 0);
    end

    // flush with 3 tags in flight
    do_reset();
    Req_Valid = 4'hF; Req_Bit = 4'b0111;
    tick(4);
    Flush = 1'b1;
    tick(1);
    Flush = 1'b0;
    @(negedge Clock);
    chk("flush.busy_draining", int'(Busy), 1);
    @(posedge Clock); #1;
    tick(3);
    Req_Valid = '0;
    tick(12);
    chk("flush.grants", gq.size(), 3);
    chk("flush.rsps", rq_id.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush.rid%0d", i), qget(rq_id, i), i);
      chk($sformatf("flush.rbit%0d", i), qget(rq_bit, i), 1);
    end
    @(negedge Clock);
    chk("flush.busy_idle", int'(Busy), 0);
    @(posedge Clock); #1;

    // reset with 2 tags in flight and 2 buffered
    do_reset();
    Rsp_Ready = 1'b0; Req_Valid = 4'hF; Req_Bit = 4'hF;
    tick(5);
    Req_Valid = '0;
    tick(3);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("midrst.rsp_valid_before", int'(Rsp_Valid), 1);
    chk("midrst.busy_before", int'(Busy), 1);
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("midrst.ready", int'(Req_Ready), 0);
    chk("midrst.drive_plus", int'(Drive_Plus), 0);
    chk("midrst.drive_minus", int'(Drive_Minus), 0);
    chk("midrst.rsp_valid", int'(Rsp_Valid), 0);
    chk("midrst.rsp_bit", int'(Rsp_Bit), 0);
    chk("midrst.rsp_id", int'(Rsp_Id), 0);
    chk("midrst.busy", int'(Busy), 0);
    chk("midrst.err", int'(Err), 0);
    @(posedge Clock); #1;
    Reset_n = 1'b1; Rsp_Ready = 1'b1;
    gq.delete(); rq_id.delete(); rq_bit.delete();
    tick(15);
    chk("midrst.no_rsps_after", rq_id.size(), 0);
    chk("midrst.no_grants_after", gq.size(), 0);
    @(negedge Clock);
    chk("midrst.busy_after", int'(Busy), 0);
    @(posedge Clock); #1;

    // pair check: both chain legs stuck high
    do_reset();
    force_plus = 1'b1; force_minus = 1'b1;
    Req_Valid = 4'b0001; Req_Bit = 4'b0001;
    tick(2);
    Req_Valid = '0;
    tick(3);
    @(negedge Clock);
    chk("pair.err_untagged", int'(Err), 0);
    @(posedge Clock); #1;
    tick(2);
    @(negedge Clock);
    chk("pair.err_set", int'(Err), ERR_EXP);
    @(posedge Clock); #1;
    tick(6);
    @(negedge Clock);
    chk("pair.err_sticky", int'(Err), ERR_EXP);
    chk("pair.rsps", rq_bit.size(), 1);
    chk("pair.rbit", qget(rq_bit, 0), 1);
    @(posedge Clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/split_radio_scheduler.md
Name: split_radio_scheduler

Overview:
- Shares one differential split-radio chain between NUM_REQ requesters.
- Round-robin grant; launches one differential bit per cycle into the chain input (Drive_Plus/Drive_Minus).
- Tags each launched bit with its requester ID and tracks it through the fixed STAGES-cycle chain.
- Captures the chain output into a credit-protected return FIFO, presented on a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STAGES, 4, chain latency in cycles from Drive_* to Chain_* sample (input stage + 3 temp stages).
- CREDITS, 8, return FIFO depth; also the max of in-flight bits plus buffered bits (>= 1).

Ports:
- Clock  in  1  sole clock.
- Reset_n  in  1  synchronous, active-low reset.
- Req_Valid  in  NUM_REQ  per-requester bit available.
- Req_Bit  in  NUM_REQ  per-requester data bit.
- Req_Ready  out  NUM_REQ  one-hot grant; transfer on Valid&Ready.
- Drive_Plus  out  1  chain positive input.
- Drive_Minus  out  1  chain negative input.
- Chain_Plus  in  1  chain positive output.
- Chain_Minus  in  1  chain negative output.
- Rsp_Valid  out  1  response available.
- Rsp_Ready  in  1  consumer accepts response.
- Rsp_Bit  out  1  returned bit.
- Rsp_Id  out  $clog2(NUM_REQ)  originating requester.
- Flush  in  1  stop granting and drain.
- Busy  out  1  state != IDLE, or a tag is in flight, or the FIFO is non-empty.
- Err  out  1  pair-check error flag (see Optional Feature).

Behaviour:
- Reset (Reset_n low at a Clock edge):
  - state=IDLE; tag pipe cleared; FIFO emptied; credits=CREDITS; RR pointer=0.
  - Drive_Plus=Drive_Minus=0; Req_Ready=0; Rsp_Valid=0; Busy=0; Err=0.
  - Reset mid-flight discards all in-flight and buffered bits.
- States:
  - IDLE→RUN when any Req_Valid=1 and Flush=0.
  - RUN→IDLE when no Req_Valid, no tags in flight and FIFO empty.
  - IDLE/RUN→DRAIN when Flush=1 (Flush wins over the same-cycle grant).
  - DRAIN→IDLE when no tags in flight and FIFO empty. Flush is ignored while in DRAIN.
- Grant:
  - Only in RUN with credits>0.
  - Search starts at RR pointer; the first Req_Valid requester gets Req_Ready, combinationally in the same cycle.
  - After a grant, pointer = granted ID + 1, mod NUM_REQ. No grant leaves the pointer unchanged.
  - At most one grant per cycle.
- Launch:
  - Registered; the cycle after a grant, Drive_Plus=bit and Drive_Minus=~bit. Otherwise both 0 (idle pair).
  - Tag {valid, id} enters a STAGES-deep shift register in the same cycle as Drive_*.
- Capture:
  - When the tag exits the shift register, sample Chain_Plus and push {Chain_Plus, id} into the FIFO.
  - Chain lines are ignored in untagged cycles.
- Response: Rsp_Valid = FIFO non-empty; Rsp_Bit/Rsp_Id = FIFO head; pop on Rsp_Valid & Rsp_Ready.
- Credits:
  - Decrement on grant; increment on pop; grant and pop in the same cycle leave credits unchanged.
  - The FIFO cannot overflow. Grant-to-Rsp_Valid latency is STAGES+2 cycles with an empty FIFO.
- Rsp_Ready held low: grants stop after CREDITS bits; the FIFO fills exactly to CREDITS. No loss and no reordering.

Optional Feature:
- Macro: SPLIT_RADIO_PAIRCHK_EN.
- Defined:
  - At tag exit, if Chain_Plus==Chain_Minus, Err sets sticky; only reset clears it.
  - The bit is still pushed using Chain_Plus.
- Undefined: Err tied to 0; no compare logic.

Decomposition:
- Package split_radio_pkg:
  - State enum {IDLE, RUN, DRAIN}.
  - Tag struct {valid, id}.
  - ID-width function of NUM_REQ.
  - Idle drive constants (0, 0).
- Sub-module split_radio_rr_arb: NUM_REQ round-robin arbiter with enable, pointer register and one-hot grant.
- The FIFO stays inline.

Test Plan:
- Single bit: requester 2 sends 1 → Drive_Plus=1, Drive_Minus=0 at cycle 1; Rsp_Bit=1, Rsp_Id=2 at cycle STAGES+2.
- Fairness: all 4 Req_Valid held for 8 cycles → grant IDs 0,1,2,3,0,1,2,3; responses return in that order.
- Backpressure: Rsp_Ready=0 with all requesters valid → exactly 8 grants, then Req_Ready=0. Rsp_Ready=1 for 1 cycle → exactly one further grant.
- Flush: Flush with 3 tags in flight → no new grants; 3 responses delivered; state returns to IDLE and Busy=0.
- Reset mid-flight: Reset_n low with 2 tags in flight and 2 FIFO entries → all outputs 0 next cycle; chain output is never pushed afterwards.
- Pair-check (with SPLIT_RADIO_PAIRCHK_EN): Chain_Plus=Chain_Minus=1 at tag exit → Err=1 and stays 1. Without the macro, Err stays 0.
